// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline: tracks in-flight writers,
// raises stalls/flushes and registers the EX operand forwarding code.
module hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic             UseRsD,
  input  logic             UseRtD,
  input  logic [REG_W-1:0] WriteRegD,
  input  logic             RegWriteD,
  input  logic             MemToRegD,
  input  logic             FlushReq,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic [3:0]       FwdTypeE,
  output logic [CNT_W-1:0] StallCount
);

  logic [REG_W-1:0] e_dest_q, e_dest_d, m_dest_q, w_dest_q;
  logic             e_wr_q, e_wr_d, m_wr_q, w_wr_q;
  logic             e_ld_q, e_ld_d, m_ld_q, w_ld_q;
  logic [3:0]       fwd_q, fwd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic src_a, src_b;
  logic match_e_a, match_e_b, match_m_a, match_m_b;
  logic lu_a, lu_b, need_a, need_b;
  logic [3:0] code_a, code_b;
  logic stall, squash;

  // WB shadow is kept for completeness; distance-3 values come from the write-first regfile.
  logic unused_wb;
  assign unused_wb = ^{w_dest_q, w_wr_q, w_ld_q};

  always_comb begin
    src_a     = UseRsD & (RsD != '0);
    src_b     = UseRtD & (RtD != '0);
    match_e_a = src_a & e_wr_q & (RsD == e_dest_q);
    match_e_b = src_b & e_wr_q & (RtD == e_dest_q);
    match_m_a = src_a & m_wr_q & (RsD == m_dest_q);
    match_m_b = src_b & m_wr_q & (RtD == m_dest_q);
    lu_a      = match_e_a & e_ld_q;
    lu_b      = match_e_b & e_ld_q;
    need_a    = match_e_a | match_m_a;
    need_b    = match_e_b | match_m_b;

    code_a = 4'd0;
    if (match_e_a)      code_a = 4'd1;
    else if (match_m_a) code_a = m_ld_q ? 4'd7 : 4'd5;

    code_b = 4'd0;
    if (match_e_b)      code_b = 4'd2;
    else if (match_m_b) code_b = m_ld_q ? 4'd8 : 4'd6;

    // The EX mux forwards a single operand, so two forwarded sources must wait a cycle.
    stall  = ~FlushReq & (lu_a | lu_b | (need_a & need_b));
    squash = stall | FlushReq;
  end

  always_comb begin
    e_dest_d = squash ? '0 : WriteRegD;
    e_wr_d   = squash ? 1'b0 : RegWriteD;
    e_ld_d   = squash ? 1'b0 : MemToRegD;

    fwd_d = 4'd0;
    if (!squash) fwd_d = need_a ? code_a : code_b;

    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      e_dest_q <= '0;
      e_wr_q   <= 1'b0;
      e_ld_q   <= 1'b0;
      m_dest_q <= '0;
      m_wr_q   <= 1'b0;
      m_ld_q   <= 1'b0;
      w_dest_q <= '0;
      w_wr_q   <= 1'b0;
      w_ld_q   <= 1'b0;
      fwd_q    <= 4'd0;
      cnt_q    <= '0;
    end else begin
      e_dest_q <= e_dest_d;
      e_wr_q   <= e_wr_d;
      e_ld_q   <= e_ld_d;
      m_dest_q <= e_dest_q;
      m_wr_q   <= e_wr_q;
      m_ld_q   <= e_ld_q;
      w_dest_q <= m_dest_q;
      w_wr_q   <= m_wr_q;
      w_ld_q   <= m_ld_q;
      fwd_q    <= fwd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign StallF     = stall;
  assign StallD     = stall;
  assign FlushE     = squash;
  assign FwdTypeE   = fwd_q;
  assign StallCount = cnt_q;

endmodule
